vc_ext_bus_bridge: RTL and testbench
====================================

// Module: vc_ext_bus_bridge
// PURPOSE
// - Parametrised successor to the CPU byte-serial external memory bridge: converts the vc cpu
//   split read/write request bus (RV bits wide) into a multiplexed 8-bit external bus
//   (address byte phases, then data byte phases).
// - Adds over the previous generation: configurable CPU width, address width and wait states;
//   one-hot address latch strobes; explicit bus output enable.
// - Sits between the cpu core and the chip pads, inside the top-level wrapper.
// PARAMETERS
// - RV          16  CPU data width: 16 or 32; NB=RV/8 bytes, BI=log2(NB) byte-index bits
// - AW          16  byte-address width: 16 or 24; AB=AW/8 address bytes
// - WAIT_CYCLES 0   extra cycles added to every external data phase (0..7)
// PORTS
// - clk        in   1       clock
// - rst_n      in   1       asynchronous active-low reset
// - ena        in   1       0 = FSM and all registers hold their value
// - raddr      in   AW-BI   read word address
// - rreq       in   1       read request
// - rdata      out  RV      read data
// - rdone      out  1       read complete pulse
// - waddr      in   AW-BI   write word address
// - wmask      in   NB      byte write enables; nonzero = write request
// - wdata      in   RV      write data
// - wdone      out  1       write complete pulse
// - bus_out    out  8       multiplexed address/data out
// - bus_in     in   8       read data in
// - bus_oe     out  1       1 = bus_out driven onto the pads
// - addr_latch out  AB      one-hot latch strobe; bit AB-1 = most significant address byte
// - bidx       out  max(BI,1)  byte index of the current data phase
// - wr         out  1       write strobe
// - rd         out  1       read strobe
// - ext_ready  in   1       external ready; present only with VC_BUS_READY_EN
// BEHAVIOUR
// - Reset values: state IDLE; all strobes, bus_oe, rdone, wdone and bidx 0; bus_out 0; rdata 0.
// - States:
//   - IDLE: sample requests.
//   - ADDR: AB cycles, MSB byte first.
//   - DATA: one phase per byte transferred.
//   - DONE: 1 cycle.
//   - TURN: 1 cycle.
//   - Sequence: IDLE -> ADDR -> DATA -> DONE -> TURN -> IDLE.
// - Arbitration: in IDLE, wmask!=0 wins over rreq. Requests not sampled in DONE or TURN.
// - Requester holds address, data and mask until it sees done, then drops the request.
// - ADDR cycle k:
//   - bus_out = address byte AB-1-k.
//   - Only addr_latch[AB-1-k] is high.
//   - bus_oe=1.
//   - Low BI address bits are driven 0.
// - Write DATA: one phase per set wmask bit, ascending byte index; masked bytes are skipped.
//   - Per phase: bidx = byte index, bus_out = that byte of wdata, wr=1, bus_oe=1.
// - Read DATA: all NB bytes, ascending byte index.
//   - Per phase: rd=1, bus_oe=0, bidx = byte index.
//   - bus_in is captured into rdata byte bidx on the last cycle of the phase.
// - Phase length = 1+WAIT_CYCLES cycles; strobes stay high for the whole phase.
// - DONE: rdone or wdone high for exactly 1 cycle; all strobes 0.
//   - rdata is stable from DONE until the next read's first capture.
// - TURN: all strobes 0; IDLE follows.
// - Latency, counted from the IDLE edge that samples the request to the done pulse:
//   1 + AB + nbytes*(1+WAIT_CYCLES) cycles (RV=16, AW=16, full read: 5 cycles).
// - ena low mid-transfer: everything freezes, including wait counters; resumes on ena high.
// - rst_n low mid-transfer: immediate return to reset values; no done pulse;
//   a partially captured rdata is cleared.
// - Requests that change while busy are ignored until the next IDLE.
// CONFIGURATION
// - VC_BUS_READY_EN defined: ext_ready port exists.
//   - After its WAIT_CYCLES, a DATA phase extends while ext_ready=0.
//   - Read capture happens on the first cycle with ext_ready=1.
//   - ADDR phases are unaffected.
// - VC_BUS_READY_EN undefined: no ext_ready port; phase length fixed at 1+WAIT_CYCLES.
// TESTING
// - RV=16, AW=16: write waddr=0x1234>>1, wmask=11, wdata=0xBEEF.
//   -> addr cycles 0x12 then 0x34; data phases bidx0 0xEF, bidx1 0xBE; wdone in cycle 5.
// - Same config, wmask=10, wdata=0xAB00.
//   -> single data phase: bidx=1, bus_out=0xAB; wdone in cycle 4; no bidx0 strobe.
// - RV=32, AW=24, WAIT_CYCLES=2: read raddr=0xABCDEF>>2; bus_in returns 0x11,0x22,0x33,0x44.
//   -> addr 0xAB,0xCD,0xEC; rd high 3 cycles per byte; rdata=0x44332211;
//      rdone in cycle 1+3+12=16.
// - wmask=01 and rreq asserted together -> write first, then the read starts after TURN.
// - rst_n pulsed low during a read data phase.
//   -> all outputs at reset values asynchronously; no rdone; next request starts from ADDR.
// - VC_BUS_READY_EN: ext_ready held low 4 cycles in the byte-0 read phase
//   -> phase stretched 4 cycles; byte captured only when ext_ready=1.

Source files
------------

// File: rtl/vc_ext_bus_bridge.sv
// vc_ext_bus_bridge
// Bridges the vc cpu split read/write request bus onto a multiplexed 8-bit
// external bus. Each transfer runs IDLE -> ADDR -> DATA -> DONE -> TURN -> IDLE.
// ADDR sends the byte address MSB first with a one-hot latch strobe per byte.
// DATA moves one byte per phase in ascending byte order. Writes skip bytes
// whose mask bit is clear; reads always fetch every byte.
// Each data phase lasts 1+WAIT_CYCLES cycles.
//
// Optional feature macro: VC_BUS_READY_EN
//   When defined, an ext_ready input exists. Once its wait cycles are used up,
//   a data phase is stretched while ext_ready is low. A read byte is captured
//   on the first cycle of the phase that sees ext_ready high.
module vc_ext_bus_bridge #(
    parameter int RV          = 16,
    parameter int AW          = 16,
    parameter int WAIT_CYCLES = 0,
    localparam int NB         = RV / 8,
    localparam int BI         = $clog2(NB),
    localparam int BIW        = (BI > 0) ? BI : 1,
    localparam int AB         = AW / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [AW-BI-1:0]  raddr,
    input  logic              rreq,
    output logic [RV-1:0]     rdata,
    output logic              rdone,
    input  logic [AW-BI-1:0]  waddr,
    input  logic [NB-1:0]     wmask,
    input  logic [RV-1:0]     wdata,
    output logic              wdone,
    output logic [7:0]        bus_out,
    input  logic [7:0]        bus_in,
    output logic              bus_oe,
    output logic [AB-1:0]     addr_latch,
    output logic [BIW-1:0]    bidx,
    output logic              wr,
    output logic              rd
`ifdef VC_BUS_READY_EN
    ,
    input  logic              ext_ready
`endif
);

    localparam int ABW = (AB > 1) ? $clog2(AB) : 1;
    localparam int WW  = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_TURN = 3'd4;

    localparam logic [ABW-1:0] ADDR_LAST = ABW'(AB - 1);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_CYCLES);

    // Sequencer state
    logic [2:0]             state_q, state_d;
    logic [ABW-1:0]         acnt_q, acnt_d;
    logic [BIW-1:0]         bidx_q, bidx_d;
    logic [WW-1:0]          wcnt_q, wcnt_d;
    logic                   op_wr_q, op_wr_d;

    // Request captured in IDLE, so later changes by the requester are ignored
    logic [AW-BI-1:0]       addr_q, addr_d;
    logic [RV-1:0]          wdata_q, wdata_d;
    logic [NB-1:0]          wmask_q, wmask_d;

    // Read data assembly register
    logic [NB-1:0][7:0]     rbyte_q, rbyte_d;

    // Helper signals
    logic                   ready;
    logic [NB-1:0]          byte_mask;
    logic                   phase_end;
    logic                   capture;
    logic [BIW:0]           first_hit;
    logic [BIW:0]           next_hit;
    logic [AW-1:0]          addr_full;
    logic [ABW-1:0]         addr_sel;
    logic [7:0]             addr_byte [AB];
    logic [7:0]             wdata_byte [NB];

`ifdef VC_BUS_READY_EN
    assign ready = ext_ready;
`else
    assign ready = 1'b1;
`endif

    // Returns {found, index} of the lowest set bit of m at or above 'from'.
    function automatic logic [BIW:0] find_from(input logic [NB-1:0] m, input int from);
        logic [BIW:0] r;
        r = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if ((i >= from) && m[i]) begin
                r = {1'b1, BIW'(i)};
            end
        end
        return r;
    endfunction

    // Reads fetch every byte; writes visit only the enabled bytes.
    assign byte_mask = op_wr_q ? wmask_q : {NB{1'b1}};
    assign first_hit = find_from(byte_mask, 0);
    assign next_hit  = find_from(byte_mask, int'(bidx_q) + 1);

    // A data phase ends after its wait cycles once the external side is ready.
    assign phase_end = (state_q == S_DATA) && (wcnt_q == WAIT_LAST) && ready;
    assign capture   = ena && phase_end && !op_wr_q;

    // Word address padded with zero byte-index bits gives the byte address.
    assign addr_full = AW'(addr_q) << BI;
    assign addr_sel  = ADDR_LAST - acnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < AB; gi++) begin : g_addr
            assign addr_byte[gi]  = addr_full[gi*8 +: 8];
            assign addr_latch[gi] = (state_q == S_ADDR) && (addr_sel == ABW'(gi));
        end
        for (gi = 0; gi < NB; gi++) begin : g_wbyte
            assign wdata_byte[gi] = wdata_q[gi*8 +: 8];
        end
    endgenerate

    assign rdata = rbyte_q;

    // Next-state logic: request arbitration, address/data sequencing and wait counting.
    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        bidx_d  = bidx_q;
        wcnt_d  = wcnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (|wmask) begin
                        op_wr_d = 1'b1;
                        addr_d  = waddr;
                        wdata_d = wdata;
                        wmask_d = wmask;
                        acnt_d  = '0;
                        state_d = S_ADDR;
                    end else if (rreq) begin
                        op_wr_d = 1'b0;
                        addr_d  = raddr;
                        acnt_d  = '0;
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (acnt_q == ADDR_LAST) begin
                        state_d = S_DATA;
                        bidx_d  = first_hit[BIW-1:0];
                        wcnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (phase_end) begin
                        if (next_hit[BIW]) begin
                            bidx_d = next_hit[BIW-1:0];
                            wcnt_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (wcnt_q != WAIT_LAST) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_TURN;
                S_TURN:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read byte capture at the closing cycle of each read data phase.
    always_comb begin
        rbyte_d = rbyte_q;
        if (capture) begin
            rbyte_d[bidx_q] = bus_in;
        end
    end

    // State and datapath registers; reset also clears any partially captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acnt_q  <= '0;
            bidx_q  <= '0;
            wcnt_q  <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rbyte_q <= '0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            bidx_q  <= bidx_d;
            wcnt_q  <= wcnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rbyte_q <= rbyte_d;
        end
    end

    // Bus output decode from the registered state; IDLE/TURN drive everything low.
    always_comb begin
        bus_out = 8'h00;
        bus_oe  = 1'b0;
        bidx    = '0;
        wr      = 1'b0;
        rd      = 1'b0;
        rdone   = 1'b0;
        wdone   = 1'b0;
        case (state_q)
            S_ADDR: begin
                bus_out = addr_byte[addr_sel];
                bus_oe  = 1'b1;
            end
            S_DATA: begin
                bidx = bidx_q;
                if (op_wr_q) begin
                    bus_out = wdata_byte[bidx_q];
                    bus_oe  = 1'b1;
                    wr      = 1'b1;
                end else begin
                    rd = 1'b1;
                end
            end
            S_DONE: begin
                rdone = !op_wr_q;
                wdone = op_wr_q;
            end
            default: begin
                bus_out = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_vc_ext_bus_bridge.sv
// Testbench for vc_ext_bus_bridge: instance A (RV=16, AW=16, no wait states)
// and instance B (RV=32, AW=24, WAIT_CYCLES=2). Expected bus events, each
// with the exact cycle it is due, are queued when a request is driven.
// A negedge monitor per instance pops and compares them.
module tb_vc_ext_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ena;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic [14:0] raddr_a, waddr_a;
    logic        rreq_a, rdone_a, wdone_a, bus_oe_a, wr_a, rd_a;
    logic [15:0] rdata_a, wdata_a;
    logic [1:0]  wmask_a, addr_latch_a;
    logic [7:0]  bus_out_a, bus_in_a;
    logic [0:0]  bidx_a;
    logic [7:0]  rbytes_a [2];

    // Instance B signals
    logic [21:0] raddr_b, waddr_b;
    logic        rreq_b, rdone_b, wdone_b, bus_oe_b, wr_b, rd_b;
    logic [31:0] rdata_b, wdata_b;
    logic [3:0]  wmask_b;
    logic [2:0]  addr_latch_b;
    logic [7:0]  bus_out_b, bus_in_b;
    logic [1:0]  bidx_b;
    logic [7:0]  rbytes_b [4];
`ifdef VC_BUS_READY_EN
    logic        ext_ready_b;
    assign bus_in_b = (rd_b && ext_ready_b) ? rbytes_b[bidx_b] : 8'hEE;
`else
    assign bus_in_b = rd_b ? rbytes_b[bidx_b] : 8'h00;
`endif
    assign bus_in_a = rd_a ? rbytes_a[bidx_a] : 8'h00;

    vc_ext_bus_bridge #(.RV(16), .AW(16), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .raddr(raddr_a), .rreq(rreq_a), .rdata(rdata_a), .rdone(rdone_a),
        .waddr(waddr_a), .wmask(wmask_a), .wdata(wdata_a), .wdone(wdone_a),
        .bus_out(bus_out_a), .bus_in(bus_in_a), .bus_oe(bus_oe_a),
        .addr_latch(addr_latch_a), .bidx(bidx_a), .wr(wr_a), .rd(rd_a)
`ifdef VC_BUS_READY_EN
        , .ext_ready(1'b1)
`endif
    );

    vc_ext_bus_bridge #(.RV(32), .AW(24), .WAIT_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .raddr(raddr_b), .rreq(rreq_b), .rdata(rdata_b), .rdone(rdone_b),
        .waddr(waddr_b), .wmask(wmask_b), .wdata(wdata_b), .wdone(wdone_b),
        .bus_out(bus_out_b), .bus_in(bus_in_b), .bus_oe(bus_oe_b),
        .addr_latch(addr_latch_b), .bidx(bidx_b), .wr(wr_b), .rd(rd_b)
`ifdef VC_BUS_READY_EN
        , .ext_ready(ext_ready_b)
`endif
    );

    typedef struct packed {
        logic [7:0] bo;
        logic [2:0] al;
        logic [1:0] bx;
        logic       wr;
        logic       rd;
        logic       oe;
        logic       rdn;
        logic       wdn;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ev_t;

    ev_t  q_a [$];
    ev_t  q_b [$];
    obs_t obs_a, obs_b;

    assign obs_a = {bus_out_a, 1'b0, addr_latch_a, 1'b0, bidx_a, wr_a, rd_a, bus_oe_a, rdone_a, wdone_a};
    assign obs_b = {bus_out_b, addr_latch_b, bidx_b, wr_b, rd_b, bus_oe_b, rdone_b, wdone_b};

    function automatic obs_t mk(input logic [7:0] bo, input logic [2:0] al, input logic [1:0] bx,
                                input logic w, input logic r, input logic oe,
                                input logic rdn, input logic wdn);
        return {bo, al, bx, w, r, oe, rdn, wdn};
    endfunction

    function automatic void push_a(input int c, input obs_t o);
        ev_t e;
        e.cyc = c;
        e.o   = o;
        q_a.push_back(e);
    endfunction

    function automatic void push_b(input int c, input obs_t o);
        ev_t e;
        e.cyc = c;
        e.o   = o;
        q_b.push_back(e);
    endfunction

    // Scoreboard monitor for instance A: every active bus cycle must match the next queued event.
    always @(negedge clk) begin
        ev_t e;
        if ((obs_a.al != 3'b000) || obs_a.wr || obs_a.rd || obs_a.rdn || obs_a.wdn) begin
            tests_run++;
            if (q_a.size() == 0) begin
                tests_failed++;
                $display("FAIL mon_a unexpected event: cyc=%0d got=%h expected none", cyc, obs_a);
            end else begin
                e = q_a.pop_front();
                if ((e.cyc != cyc) || (e.o !== obs_a)) begin
                    tests_failed++;
                    $display("FAIL mon_a event: got cyc=%0d obs=%h, expected cyc=%0d obs=%h",
                             cyc, obs_a, e.cyc, e.o);
                end
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge clk) begin
        ev_t e;
        if ((obs_b.al != 3'b000) || obs_b.wr || obs_b.rd || obs_b.rdn || obs_b.wdn) begin
            tests_run++;
            if (q_b.size() == 0) begin
                tests_failed++;
                $display("FAIL mon_b unexpected event: cyc=%0d got=%h expected none", cyc, obs_b);
            end else begin
                e = q_b.pop_front();
                if ((e.cyc != cyc) || (e.o !== obs_b)) begin
                    tests_failed++;
                    $display("FAIL mon_b event: got cyc=%0d obs=%h, expected cyc=%0d obs=%h",
                             cyc, obs_b, e.cyc, e.o);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1;
        rreq_a = 0; raddr_a = '0; waddr_a = '0; wmask_a = '0; wdata_a = '0;
        rreq_b = 0; raddr_b = '0; waddr_b = '0; wmask_b = '0; wdata_b = '0;
`ifdef VC_BUS_READY_EN
        ext_ready_b = 1'b1;
`endif
        for (int i = 0; i < 2; i++) rbytes_a[i] = 8'h00;
        for (int i = 0; i < 4; i++) rbytes_b[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (obs_a !== '0) begin tests_failed++; $display("FAIL reset_a_ctrl: got %h expected 0", obs_a); end
        tests_run++;
        if (rdata_a !== 16'h0) begin tests_failed++; $display("FAIL reset_a_rdata: got %h expected 0", rdata_a); end
        tests_run++;
        if (obs_b !== '0) begin tests_failed++; $display("FAIL reset_b_ctrl: got %h expected 0", obs_b); end
        tests_run++;
        if (rdata_b !== 32'h0) begin tests_failed++; $display("FAIL reset_b_rdata: got %h expected 0", rdata_b); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({obs_a, obs_b} !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h/%h expected 0/0", obs_a, obs_b);
        end
        $display("[TB] reset checked");
    endtask

    task automatic do_write_a(input logic [15:0] ba, input logic [1:0] m, input logic [15:0] d,
                              input string tag);
        int base, k;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        waddr_a = ba[15:1]; wmask_a = m; wdata_a = d;
        base = cyc;
        push_a(base + 1, mk(ba[15:8], 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 2, mk({ba[7:1], 1'b0}, 3'b001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        k = 3;
        for (int i = 0; i < 2; i++) begin
            if (m[i]) begin
                push_a(base + k, mk(d[i*8 +: 8], 3'b000, 2'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
                k++;
            end
        end
        push_a(base + k, mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (wdone_a) seen = 1;
        end
        #1;
        wmask_a = '0;
        tests_run++;
        if (!seen || q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL %s drain: got done=%0d left=%0d expected done=1 left=0", tag, seen, q_a.size());
        end
        $display("[TB] write %s addr=%h mask=%b data=%h", tag, ba, m, d);
    endtask

    task automatic do_read_a(input logic [15:0] ba, input logic [7:0] b0, input logic [7:0] b1,
                             input string tag);
        int base;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        rbytes_a[0] = b0; rbytes_a[1] = b1;
        raddr_a = ba[15:1]; rreq_a = 1'b1;
        base = cyc;
        push_a(base + 1, mk(ba[15:8], 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 2, mk({ba[7:1], 1'b0}, 3'b001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 3, mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push_a(base + 4, mk(8'h00, 3'b000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push_a(base + 5, mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (rdone_a) seen = 1;
        end
        #1;
        rreq_a = 1'b0;
        tests_run++;
        if (!seen || q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL %s drain: got done=%0d left=%0d expected done=1 left=0", tag, seen, q_a.size());
        end
        tests_run++;
        if (rdata_a !== {b1, b0}) begin
            tests_failed++;
            $display("FAIL %s rdata: got %h expected %h", tag, rdata_a, {b1, b0});
        end
        $display("[TB] read %s addr=%h rdata=%h", tag, ba, rdata_a);
    endtask

    task automatic test_write_full();
        do_write_a(16'h1234, 2'b11, 16'hBEEF, "write_full");
    endtask

    task automatic test_read();
        do_read_a(16'h2468, 8'h5A, 8'hC3, "read_a");
    endtask

    // Partial write; rdata must keep the previous read's value.
    task automatic test_write_partial();
        do_write_a(16'h5678, 2'b10, 16'hAB00, "write_partial");
        tests_run++;
        if (rdata_a !== 16'hC35A) begin
            tests_failed++;
            $display("FAIL rdata_stable: got %h expected c35a", rdata_a);
        end
    endtask

    // Simultaneous write and read requests: the write goes first, the read follows TURN.
    task automatic test_back_to_back();
        int base;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        waddr_a = 16'h0246 >> 1; wmask_a = 2'b01; wdata_a = 16'h0077;
        raddr_a = 16'h9ABC >> 1; rreq_a = 1'b1;
        rbytes_a[0] = 8'h3C; rbytes_a[1] = 8'hD2;
        base = cyc;
        push_a(base + 1,  mk(8'h02, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 2,  mk(8'h46, 3'b001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 3,  mk(8'h77, 3'b000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 4,  mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        push_a(base + 7,  mk(8'h9A, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 8,  mk(8'hBC, 3'b001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 9,  mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push_a(base + 10, mk(8'h00, 3'b000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push_a(base + 11, mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            if (wdone_a) wmask_a = 2'b00;
            if (rdone_a) seen = 1;
        end
        #1;
        rreq_a = 1'b0;
        tests_run++;
        if (!seen || q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL back_to_back drain: got done=%0d left=%0d expected done=1 left=0", seen, q_a.size());
        end
        tests_run++;
        if (rdata_a !== 16'hD23C) begin
            tests_failed++;
            $display("FAIL back_to_back rdata: got %h expected d23c", rdata_a);
        end
        $display("[TB] back_to_back write then read rdata=%h", rdata_a);
    endtask

    // Reset during the second read data phase, after byte 0 has been captured.
    task automatic test_reset_mid();
        int base;
        repeat (3) @(posedge clk);
        #1;
        rbytes_a[0] = 8'h99; rbytes_a[1] = 8'h88;
        raddr_a = 16'h1357 >> 1; rreq_a = 1'b1;
        base = cyc;
        push_a(base + 1, mk(8'h13, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 2, mk(8'h56, 3'b001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_a(base + 3, mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push_a(base + 4, mk(8'h00, 3'b000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs_a !== '0) begin tests_failed++; $display("FAIL reset_mid ctrl: got %h expected 0", obs_a); end
        tests_run++;
        if (rdata_a !== 16'h0) begin tests_failed++; $display("FAIL reset_mid rdata: got %h expected 0", rdata_a); end
        rreq_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        tests_run++;
        if (q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid events: got left=%0d expected 0", q_a.size());
        end
        $display("[TB] reset mid-read aborted");
        do_read_a(16'h1357 & 16'hFFFE, 8'h21, 8'h43, "read_after_reset");
    endtask

    // Instance B read. mode 0: plain, 1: ena low two cycles in byte 0, 2: ext_ready low four cycles.
    task automatic do_read_b(input logic [23:0] ba, input logic [31:0] val, input int mode,
                             input string tag);
        int base, k, extra, len;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rbytes_b[i] = val[i*8 +: 8];
        raddr_b = ba[23:2]; rreq_b = 1'b1;
        base = cyc;
        extra = (mode == 0) ? 0 : ((mode == 1) ? 2 : 4);
        push_b(base + 1, mk(ba[23:16], 3'b100, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_b(base + 2, mk(ba[15:8],  3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        push_b(base + 3, mk({ba[7:2], 2'b00}, 3'b001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        k = 4;
        for (int i = 0; i < 4; i++) begin
            len = 3 + ((i == 0) ? extra : 0);
            for (int j = 0; j < len; j++) begin
                push_b(base + k, mk(8'h00, 3'b000, 2'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                k++;
            end
        end
        push_b(base + k, mk(8'h00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        if (mode == 1) begin
            repeat (4) @(posedge clk);
            #1;
            ena = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            ena = 1'b1;
        end
`ifdef VC_BUS_READY_EN
        if (mode == 2) begin
            repeat (6) @(posedge clk);
            #1;
            ext_ready_b = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            ext_ready_b = 1'b1;
        end
`endif
        seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            if (rdone_b) seen = 1;
        end
        #1;
        rreq_b = 1'b0;
        tests_run++;
        if (!seen || q_b.size() != 0) begin
            tests_failed++;
            $display("FAIL %s drain: got done=%0d left=%0d expected done=1 left=0", tag, seen, q_b.size());
        end
        tests_run++;
        if (rdata_b !== val) begin
            tests_failed++;
            $display("FAIL %s rdata: got %h expected %h", tag, rdata_b, val);
        end
        $display("[TB] read %s addr=%h rdata=%h", tag, ba, rdata_b);
    endtask

    task automatic test_wait_read();
        do_read_b(24'hABCDEF, 32'h44332211, 0, "wait_read");
    endtask

    task automatic test_ena_freeze();
        do_read_b(24'h102030, 32'hA5B6C7D8, 1, "ena_freeze");
    endtask

`ifdef VC_BUS_READY_EN
    task automatic test_ext_ready();
        do_read_b(24'h0FF0F0, 32'h76543210, 2, "ext_ready");
    endtask
`endif

    initial begin
        test_reset();
        test_write_full();
        test_read();
        test_write_partial();
        test_back_to_back();
        test_reset_mid();
        test_wait_read();
        test_ena_freeze();
`ifdef VC_BUS_READY_EN
        test_ext_ready();
`endif
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
